noc_local_eject: RTL

- Ejection stage of the local output port, directly downstream of the local port controller.
- Consumes the controller's per-VC granted-port selections and steers flits from the 5 router input ports into per-VC buffers.
- Round-robin merges those buffers onto the single local network-interface link.
- On each tail flit, pulses a per-VC free that pops the controller's grant queue.

---
 rtl/noc_local_eject_pkg.sv | 29 ++
 rtl/Noc_fifo.sv | 98 +++++++++
 rtl/noc_eject_vc_ctrl.sv | 82 ++++++++
 rtl/noc_local_eject.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/noc_local_eject_pkg.sv
// -----------------------------------------------------------------------------
// noc_local_eject_pkg
// Shared NoC definitions for the local ejection stage: default VC count and
// flit width, number of router input ports, the per-VC ejection FSM state
// encoding, the buffered flit record and a one-hot helper.
// -----------------------------------------------------------------------------
package noc_local_eject_pkg;

  localparam int Noc_VC_Channel = 2;
  localparam int Noc_Flit_Width = 16;
  localparam int NOC_PORTS      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } noc_eject_state_e;

  typedef struct packed {
    logic                      tail;
    logic [Noc_Flit_Width-1:0] data;
  } noc_flit_t;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  function automatic logic onehot_port(input logic [NOC_PORTS-1:0] v);
    return (v != '0) && ((v & (v - NOC_PORTS'(1))) == '0);
  endfunction

endpackage

// File: rtl/Noc_fifo.sv
// -----------------------------------------------------------------------------
// Noc_fifo
// Synchronous FIFO used for NoC flit buffering. DEPTH must be a power of 2.
// FLAG_FF_OUT selects registered full/empty flags, DATA_FF_OUT selects a
// registered head-of-queue output; with both 0 the flags decode the occupancy
// counter and rdata_o reads the storage directly (show-ahead).
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   write request and data
//   pop_i             read request (consumes rdata_o)
//   rdata_o           head entry
//   full_o, empty_o   status flags
// -----------------------------------------------------------------------------
module Noc_fifo #(
  parameter int DATA_W      = 17,
  parameter int DEPTH       = 2,
  parameter int FLAG_FF_OUT = 0,
  parameter int DATA_FF_OUT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty, do_push, do_pop;

  assign do_push = push_i && (!full || pop_i);
  assign do_pop  = pop_i && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  if (FLAG_FF_OUT != 0) begin : g_flag_ff
    logic full_q, empty_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        full_q  <= 1'b0;
        empty_q <= 1'b1;
      end else begin
        full_q  <= (count_d == CNT_W'(DEPTH));
        empty_q <= (count_d == '0);
      end
    end
    assign full  = full_q;
    assign empty = empty_q;
  end else begin : g_flag_comb
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
  end

  if (DATA_FF_OUT != 0) begin : g_data_ff
    logic [DATA_W-1:0] head_q;
    // The new head is the entry being written when the write lands exactly
    // on the post-pop read slot (FIFO drained or empty this cycle).
    always_ff @(posedge clk_i) begin
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_q <= wdata_i;
      else                                   head_q <= mem_q[rd_ptr_d];
    end
    assign rdata_o = head_q;
  end else begin : g_data_comb
    assign rdata_o = mem_q[rd_ptr_q];
  end

  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/noc_eject_vc_ctrl.sv
// -----------------------------------------------------------------------------
// noc_eject_vc_ctrl
// Per-VC ejection FSM (IDLE / ACTIVE / RELEASE). Latches the granted input
// port from the controller's queue head, opens that port for flits of this VC
// while the VC buffer has room, and spends one RELEASE cycle after the tail so
// the controller pops its queue before IDLE can look at the head again.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   grant_i         one-hot granted input port (queue head)
//   grant_valid_i   grant_i holds a live entry
//   in_valid_i      per-port flit valid
//   in_match_i      per-port: flit VC equals this VC
//   in_tail_i       per-port tail marker
//   full_i          this VC's buffer is full
//   ready_o         per-port accept for this VC
//   port_o          latched one-hot port (steers the write data)
//   push_o          a flit is accepted this cycle
//   free_o          one-cycle pulse in RELEASE
//   err_o           pulse: live grant that is not one-hot while IDLE
// -----------------------------------------------------------------------------
module noc_eject_vc_ctrl
  import noc_local_eject_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NOC_PORTS-1:0] grant_i,
  input  logic                 grant_valid_i,
  input  logic [NOC_PORTS-1:0] in_valid_i,
  input  logic [NOC_PORTS-1:0] in_match_i,
  input  logic [NOC_PORTS-1:0] in_tail_i,
  input  logic                 full_i,
  output logic [NOC_PORTS-1:0] ready_o,
  output logic [NOC_PORTS-1:0] port_o,
  output logic                 push_o,
  output logic                 free_o,
  output logic                 err_o
);

  noc_eject_state_e     state_q, state_d;
  logic [NOC_PORTS-1:0] port_q, port_d;
  logic                 tail_acc;

  always_comb begin
    ready_o  = (state_q == ACTIVE && !full_i) ? (port_q & in_match_i) : '0;
    push_o   = |(ready_o & in_valid_i);
    tail_acc = |(ready_o & in_valid_i & in_tail_i);
    free_o   = (state_q == RELEASE);
    port_o   = port_q;
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    err_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid_i) begin
          if (onehot_port(grant_i)) begin
            port_d  = grant_i;
            state_d = ACTIVE;
          end else begin
            err_o = 1'b1;
          end
        end
      end
      ACTIVE:  if (tail_acc) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

endmodule

// File: rtl/noc_local_eject.sv
// -----------------------------------------------------------------------------
// noc_local_eject
// Ejection stage of the local output port. Steers flits from the 5 router
// input ports into per-VC buffers under control of the local port
// controller's per-VC grants, then round-robin merges the buffers (flit
// interleaved, VC tag carried) onto the single local NI link through a
// valid/ready output register. Tail acceptance pulses free_o[v] one cycle
// later to pop the controller's grant queue.
// Ports:
//   noc_clk, noc_rst          clock, synchronous active-high reset
//   grant_i, grant_valid_i    per-VC queued one-hot grant from the controller
//   free_o                    per-VC packet-done pulse
//   in_valid/vc/tail/data     per-port flit inputs, in_ready per port
//   out_valid/vc/tail/data    flit to the local NI, out_ready from the NI
//   err_o                     sticky: non-one-hot live grant observed
// -----------------------------------------------------------------------------
module noc_local_eject
  import noc_local_eject_pkg::*;
#(
  parameter  int CHANNELS  = Noc_VC_Channel,
  parameter  int FLIT_W    = Noc_Flit_Width,
  parameter  int BUF_DEPTH = 2,
  localparam int VCW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                noc_clk,
  input  logic                                noc_rst,
  input  logic [CHANNELS-1:0][NOC_PORTS-1:0]  grant_i,
  input  logic [CHANNELS-1:0]                 grant_valid_i,
  output logic [CHANNELS-1:0]                 free_o,
  input  logic [NOC_PORTS-1:0]                in_valid,
  input  logic [NOC_PORTS-1:0][VCW-1:0]       in_vc,
  input  logic [NOC_PORTS-1:0]                in_tail,
  input  logic [NOC_PORTS-1:0][FLIT_W-1:0]    in_data,
  output logic [NOC_PORTS-1:0]                in_ready,
  output logic                                out_valid,
  output logic [VCW-1:0]                      out_vc,
  output logic                                out_tail,
  output logic [FLIT_W-1:0]                   out_data,
  input  logic                                out_ready,
  output logic                                err_o
);

  logic [CHANNELS-1:0][NOC_PORTS-1:0] ready_v;
  logic [CHANNELS-1:0]                push_v, err_v, full_v, empty_v;
  logic [CHANNELS-1:0]                pop_v, fifo_push_v, fifo_pop_v, avail_v;
  logic [CHANNELS-1:0][FLIT_W:0]      wflit, head, cand;

  logic              load, found;
  logic [VCW-1:0]    win;
  logic [VCW-1:0]    rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [VCW-1:0]    out_vc_q, out_vc_d;
  logic              out_tail_q, out_tail_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;
  logic              err_q, err_d;

  for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
    logic [NOC_PORTS-1:0] match, port_sel;
    logic [FLIT_W:0]      wsel;

    always_comb begin
      match = '0;
      wsel  = '0;
      for (int p = 0; p < NOC_PORTS; p++) begin
        match[p] = (in_vc[p] == VCW'(v));
        if (port_sel[p]) wsel = {in_tail[p], in_data[p]};
      end
    end

    noc_eject_vc_ctrl u_ctrl (
      .clk_i         (noc_clk),
      .rst_i         (noc_rst),
      .grant_i       (grant_i[v]),
      .grant_valid_i (grant_valid_i[v]),
      .in_valid_i    (in_valid),
      .in_match_i    (match),
      .in_tail_i     (in_tail),
      .full_i        (full_v[v]),
      .ready_o       (ready_v[v]),
      .port_o        (port_sel),
      .push_o        (push_v[v]),
      .free_o        (free_o[v]),
      .err_o         (err_v[v])
    );

    Noc_fifo #(
      .DATA_W      (FLIT_W + 1),
      .DEPTH       (BUF_DEPTH),
      .FLAG_FF_OUT (0),
      .DATA_FF_OUT (0)
    ) u_buf (
      .clk_i   (noc_clk),
      .rst_i   (noc_rst),
      .push_i  (fifo_push_v[v]),
      .wdata_i (wflit[v]),
      .pop_i   (fifo_pop_v[v]),
      .rdata_o (head[v]),
      .full_o  (full_v[v]),
      .empty_o (empty_v[v])
    );

    assign wflit[v]   = wsel;
    // An empty buffer lets an incoming flit go straight to the output
    // register in the cycle it is accepted (one-cycle ejection latency).
    assign avail_v[v] = !empty_v[v] || push_v[v];
    assign cand[v]    = empty_v[v] ? wflit[v] : head[v];
    assign fifo_push_v[v] = push_v[v] && !(empty_v[v] && pop_v[v]);
    assign fifo_pop_v[v]  = pop_v[v] && !empty_v[v];
  end

  always_comb begin
    in_ready = '0;
    for (int v = 0; v < CHANNELS; v++) in_ready = in_ready | ready_v[v];
  end

  // Round-robin pick: first available VC at or after the pointer.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % CHANNELS;
      if (!found && avail_v[idx]) begin
        found = 1'b1;
        win   = VCW'(idx);
      end
    end
  end

  assign load = !out_valid_q || out_ready;

  always_comb begin
    for (int v = 0; v < CHANNELS; v++) pop_v[v] = load && found && (win == VCW'(v));
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_vc_d    = out_vc_q;
    out_tail_d  = out_tail_q;
    out_data_d  = out_data_q;
    rr_d        = rr_q;
    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_vc_d                 = win;
        {out_tail_d, out_data_d} = cand[win];
        rr_d = (int'(win) == CHANNELS - 1) ? '0 : win + VCW'(1);
      end
    end
    err_d = err_q | (|err_v);
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      out_valid_q <= 1'b0;
      out_vc_q    <= '0;
      out_tail_q  <= 1'b0;
      out_data_q  <= '0;
      rr_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      out_tail_q  <= out_tail_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_vc    = out_vc_q;
  assign out_tail  = out_tail_q;
  assign out_data  = out_data_q;
  assign err_o     = err_q;

endmodule
